// File: rtl/parallel_serializer.sv
// Parallel-to-serial feeder for the sequence-detector stage.
// One-word hold buffer keeps back-to-back words streaming with no gap.
module parallel_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] FILL = {WIDTH{IDLE_BIT}};

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             accept;
    logic             at_last;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= FILL;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign in_ready = !hold_full_q;
    assign accept   = in_valid && in_ready;
    assign at_last  = (cnt_q == CNT_LAST);

    // The outgoing bit always sits at one end of shreg; shifting pulls in idle fill.
    always_comb begin
        if (MSB_FIRST != 0) shifted = {shreg_q[WIDTH-2:0], IDLE_BIT};
        else                shifted = {IDLE_BIT, shreg_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        shreg_d = in_data;
                    end else begin
                        shreg_d = FILL;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    shreg_d = shifted;
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_bit   = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    assign out_valid = (state_q == SHIFT);
    assign last      = out_valid && at_last;
    assign busy      = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_parallel_serializer.sv
// Directed bench for parallel_serializer (MSB-first and LSB-first instances).
module tb_parallel_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, out_bit, out_valid, last, busy;
    logic [7:0] l_data = '0;
    logic       l_valid = 1'b0;
    logic       l_ready, l_bit, l_ovalid, l_last, l_busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    parallel_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
        .last(last), .busy(busy)
    );

    parallel_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid),
        .in_ready(l_ready), .out_bit(l_bit), .out_valid(l_ovalid),
        .last(l_last), .busy(l_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".out_bit"}, out_bit, 1'b0);
        chk({tag, ".out_valid"}, out_valid, 1'b0);
        chk({tag, ".last"}, last, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".in_ready"}, in_ready, 1'b1);
    endtask

    // Called just after the accepting edge; leaves time just after the last-bit edge.
    task automatic expect_word(input string tag, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            chk({tag, ".bit"}, out_bit, w[7-i]);
            chk({tag, ".valid"}, out_valid, 1'b1);
            chk({tag, ".last"}, last, (i == 7));
            if (i < 7) step();
        end
    endtask

    initial begin
        logic [15:0] seq;
        logic [7:0]  lw;

        // Reset asserted mid-cycle takes effect immediately
        step();
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        chk("rst_async.lsb_valid", l_ovalid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_reset_vals("rst_hold");
        end
        rst = 1'b0;
        step();
        chk_reset_vals("post_rst");

        // Single word, MSB first
        in_data = 8'hB0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data = 8'h00;
        expect_word("single_B0", 8'hB0);
        step();
        chk("single_B0.idle_valid", out_valid, 1'b0);
        chk("single_B0.idle_bit", out_bit, 1'b0);
        chk("single_B0.idle_busy", busy, 1'b0);

        // Back-to-back with hold buffer
        step();
        seq = 16'hB4A5;
        in_data = 8'hB4;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            if (i == 0) in_data = 8'hA5;
            if (i == 1) begin
                in_valid = 1'b0;
                in_data = 8'h00;
            end
            chk("b2b.bit", out_bit, seq[15-i]);
            chk("b2b.valid", out_valid, 1'b1);
            chk("b2b.last", last, (i == 7) || (i == 15));
            chk("b2b.in_ready", in_ready, (i == 0) || (i >= 8));
            if (i < 15) step();
        end
        step();
        chk("b2b.idle_valid", out_valid, 1'b0);
        chk("b2b.idle_busy", busy, 1'b0);

        // LSB-first instance: 0D -> 1,0,1,1,0,0,0,0
        lw = 8'b0000_1101;
        l_data = 8'h0D;
        l_valid = 1'b1;
        step();
        l_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_0D.bit", l_bit, lw[i]);
            chk("lsb_0D.valid", l_ovalid, 1'b1);
            chk("lsb_0D.last", l_last, (i == 7));
            if (i < 7) step();
        end
        step();
        chk("lsb_0D.idle_valid", l_ovalid, 1'b0);

        // Direct reload offered only in the last-bit cycle
        in_data = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("reload_3C.bit", out_bit, lw[0] ^ lw[0] ^ (8'h3C >> (7 - i)) & 1'b1);
            chk("reload_3C.last", last, (i == 7));
            if (i == 7) begin
                chk("reload.in_ready", in_ready, 1'b1);
                in_data = 8'hC3;
                in_valid = 1'b1;
            end else begin
                step();
            end
        end
        step();
        in_valid = 1'b0;
        in_data = 8'h00;
        expect_word("reload_C3", 8'hC3);
        step();
        chk("reload.idle_valid", out_valid, 1'b0);

        // Reset during bit 3 with the hold buffer full
        in_data = 8'hFF;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        in_data = 8'h00;
        chk("midrst.hold_full", in_ready, 1'b0);
        step();
        step();
        chk("midrst.bit3", out_bit, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("midrst_async");
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("midrst.no_residual_valid", out_valid, 1'b0);
            chk("midrst.no_residual_bit", out_bit, 1'b0);
        end
        in_data = 8'h96;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        expect_word("after_rst_96", 8'h96);
        step();
        chk("after_rst.idle_valid", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/parallel_serializer.md
# parallel_serializer

Upstream feeder for the serial sequence-detector stage. It accepts parallel words over a valid/ready handshake and emits them one bit per clock on `out_bit`, which drives the detector's serial input directly. A one-word holding buffer lets the next word be accepted while the current word shifts, so back-to-back words stream with no idle cycles. When no data is pending, the line rests at a fixed idle level.

## Interface
- `WIDTH`, default 8: bits per word; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, default 0: level driven on `out_bit` when no word is shifting.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  parallel word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `out_bit`  out  1  serial bit to the detector's serial input; registered.
- `out_valid`  out  1  `out_bit` carries a data bit (not idle fill).
- `last`  out  1  `out_bit` is the final bit of its word.
- `busy`  out  1  a word is shifting or held.

## Operation
- Storage:
  - `shreg`: WIDTH-bit shift register.
  - bit counter: $clog2(WIDTH) bits.
  - `hold`: WIDTH-bit register with `hold_full` flag.
  - state: IDLE or SHIFT.
- Accept condition: `in_valid && in_ready`. `in_ready = !hold_full`; it is combinational from registered state only.
- IDLE + accept:
  - word loads into `shreg`; counter = 0; state → SHIFT.
  - `out_bit` = first bit of the word.
- SHIFT, per edge:
  - counter increments;
  - `out_bit` takes the next bit in MSB_FIRST order.
- SHIFT + accept, not on the last-bit edge: word goes to `hold`; `hold_full` = 1.
- Last-bit edge (counter == WIDTH-1), in priority order:
  - `hold_full`: `hold` → `shreg`, `hold_full` → 0, counter = 0, stay in SHIFT.
  - else if accept: `in_data` → `shreg` directly, counter = 0, stay in SHIFT.
  - else: state → IDLE, `out_bit` = IDLE_BIT, `out_valid` = 0.
- `last` = `out_valid` && counter == WIDTH-1.
- `busy` = (state == SHIFT) || `hold_full`.
- Words are never dropped, reordered or partially sent.
- `in_data` is sampled only on the accepting edge.

## Timing
- Reset values, applied asynchronously:
  - state IDLE, counter 0, `hold_full` 0;
  - `out_bit` = IDLE_BIT; `out_valid`, `last`, `busy` = 0; `in_ready` = 1.
- Latency: a word accepted on edge k shows its first bit after edge k. Bit i is valid between edges k+i and k+i+1, for i = 0..WIDTH-1.
- Throughput: 1 bit/clock sustained, with zero gap between consecutive words whenever the next word is held or accepted by the last-bit edge.
- `out_bit` is stable for a full cycle, so the downstream detector samples it at the following edge.
- `in_ready` is 0 while `hold_full`. This includes the last-bit cycle of a full-hold transfer; the word accepted then is not lost, it simply waits one cycle.
- Reset mid-word clears both `shreg` and `hold`; no residual bits are emitted after release.
- Holding `in_valid` high without `in_ready` is legal; the word is accepted on the first edge with `in_ready` = 1.

## Test plan
- Reset: assert `rst` mid-cycle → immediately `out_bit` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1. Hold `rst` for 3 clocks; outputs stay at these values.
- Single word, MSB_FIRST = 1: accept 8'hB0 on edge k → `out_bit` = 1,0,1,1,0,0,0,0 on cycles k..k+7 and `last` only on k+7. Cycle k+8 shows `out_valid` = 0, `out_bit` = 0. The attached detector output pulses exactly once, in the cycle after edge k+4.
- Back-to-back: present 8'hB4 then 8'hA5 with `in_valid` constantly high.
  - B4 accepted on edge 0; A5 taken into `hold` on edge 1, after which `in_ready` = 0.
  - 16 contiguous valid bits follow: 10110100 10100101.
  - `in_ready` returns to 1 after edge 8.
- LSB first (MSB_FIRST = 0): accept 8'h0D → bit sequence 1,0,1,1,0,0,0,0.
- Direct reload: hold empty and a word offered exactly in the last-bit cycle → it is accepted on that edge, and its first bit follows the previous word's last bit with no idle cycle.
- Reset mid-operation: assert `rst` during bit 3 of a word while `hold_full` = 1 → outputs return to reset values at once. After release, no bits of either word appear, and the next accepted word serializes normally.
